alu_iter_unit: RTL and testbench
================================

// Module: alu_iter_unit
// PURPOSE
//  Parametrised successor to the 32-bit combinational ALU; width is set by parameter.
//  - Adds a 4-bit opcode, unsigned multiply (MULU) and unsigned divide (DIVU) as
//    iterative multi-cycle ops.
//  - Registered results, valid/ready handshake on both sides.
//  - Sits in the execute stage of the multi-cycle datapath; the stage stalls on in_ready=0.
// PARAMETERS
//  WIDTH   32  operand/result width; >=8, power of two
//  SHW     $clog2(WIDTH)  shift-amount bits taken from b[SHW-1:0]
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      synchronous, active-high
//  in_valid      in   1      operands/opcode valid
//  in_ready      out  1      unit can accept (IDLE only)
//  op            in   4      opcode (see BEHAVIOUR)
//  a, b          in   WIDTH  operands
//  carry_in      in   1      used by ADD only
//  out_valid     out  1      result valid, held until out_ready
//  out_ready     in   1      consumer accepts result
//  res_lo        out  WIDTH  result / product low / quotient
//  res_hi        out  WIDTH  product high / remainder; 0 for 1-cycle ops
//  carry_out     out  1      ADD carry; SUB no-borrow (a>=b); else 0
//  zero          out  1      res_lo==0
//  div_by_zero   out  1      DIVU with b==0
//  illegal_op    out  1      op >= 4'b1010
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1 on the cycle after reset; every other output 0.
//  - Reset wins over all activity, including mid-MUL/DIV; partial results are discarded.
//  Opcodes: 0 AND, 1 OR, 2 ADD (a+b+carry_in), 3 SUB, 4 XOR, 5 SRL, 6 SLL,
//   7 SLT (signed, res_lo=1/0), 8 MULU, 9 DIVU, 10-15 illegal.
//  - Illegal ops: res_lo=res_hi=0, illegal_op=1, latency 1.
//  FSM IDLE -> (EXEC | MUL | DIV) -> DONE -> IDLE.
//  - IDLE: in_ready=1; accept on in_valid; latch op, a, b, carry_in.
//  - 1-cycle ops (0-7, illegal): result registered at accept; DONE next cycle.
//    Latency 1 (out_valid is high the cycle after accept).
//  - MUL: shift-and-add, 1 bit/cycle, WIDTH iterations; 2*WIDTH product {res_hi,res_lo}.
//    out_valid rises WIDTH+1 cycles after accept.
//  - DIV: restoring, 1 bit/cycle, WIDTH iterations; latency WIDTH+1.
//    b==0 skips iteration: res_lo=all ones, res_hi=a, div_by_zero=1, latency 1.
//  - DONE: out_valid=1; all outputs held stable until out_valid&&out_ready,
//    then IDLE (in_ready=1 next cycle).
//  - No accept in DONE: back-to-back throughput is 1 op per 2 cycles minimum.
//  - in_ready=0 in EXEC/MUL/DIV/DONE; in_valid is ignored there (no buffering).
//  - Iteration counter SHW+1 bits; wraps never (cleared on accept).
//  - Flags (carry_out, zero, div_by_zero, illegal_op) are valid only while out_valid=1.
// STRUCTURE
//  Shared package alu_pkg:
//   - opcode localparams OP_AND..OP_DIVU
//   - FSM state encoding ST_IDLE/ST_EXEC/ST_MUL/ST_DIV/ST_DONE
//  Sub-module alu_iter_muldiv: iterative mul/div datapath, counter and done pulse.
//   - Top level holds the FSM, the 1-cycle op logic and the output registers.
// TESTING (WIDTH=32)
//  ADD a=FFFFFFFF b=0 cin=1 -> res_lo=0, carry_out=1, zero=1, out_valid 1 cycle after accept.
//  SRL a=80000110 b=3 -> 10000022; SLT a=80000000 b=1 -> res_lo=1.
//  MULU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE lo=00000001, out_valid exactly 33 cycles after accept.
//  DIVU 100/7 -> lo=14 hi=2.
//  DIVU 0x1234/0 -> lo=FFFFFFFF hi=1234, div_by_zero=1, latency 1.
//  Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, extra in_valid ignored.
//  reset=1 at cycle 10 of MULU -> next cycle IDLE, out_valid=0, in_ready=1; a new ADD completes normally.
//  op=4'b1100 -> illegal_op=1, res_lo=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM states and opcode helpers.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;

    // ST_EXEC is part of the encoding, but single-cycle ops are evaluated on the
    // accept edge itself, so the FSM moves from ST_IDLE straight to ST_DONE for them.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MUL  = 3'd2,
        ST_DIV  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Opcodes 10-15 carry no operation and complete in one cycle with illegal_op set.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return op >= 4'd10;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-and-add) and divide (restoring) datapath.
// One bit per cycle, WIDTH iterations; res_lo/res_hi show the value the registers
// take on the current step, so the parent can capture the final result on the
// same edge that done is high.
module alu_iter_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             done
);

    localparam logic [SHW:0] LAST_STEP = (SHW + 1)'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic             is_div_q, is_div_d;
    logic [SHW:0]     cnt_q, cnt_d;
    // acc: partial product high half / partial remainder
    // lo:  multiplier being consumed / dividend shifting out, quotient shifting in
    // opd: multiplicand / divisor
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opd_q, opd_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] acc_step, lo_step;

    // One iteration of either algorithm, selected by the latched mode.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {acc_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opd_q};
        // When div_ge holds the true difference is below 2^WIDTH, so modular
        // subtraction on the low bits is exact.
        div_diff  = div_shift[WIDTH-1:0] - opd_q;
        if (is_div_q) begin
            acc_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_step  = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            acc_step = mul_sum[WIDTH:1];
            lo_step  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        done   = busy_q && (cnt_q == LAST_STEP);
        res_lo = lo_step;
        res_hi = acc_step;
    end

    // Load operands on start, otherwise step and count while busy.
    always_comb begin
        // NOTE: every _d starts from its _q, so no path through this block leaves a
        // variable unassigned -- that is what keeps synthesis from inferring a latch.
        busy_d   = busy_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opd_d    = opd_q;
        if (start) begin
            busy_d   = 1'b1;
            is_div_d = is_div;
            cnt_d    = '0;
            acc_d    = '0;
            lo_d     = a;
            opd_d    = b;
        end else if (busy_q) begin
            acc_d = acc_step;
            lo_d  = lo_step;
            cnt_d = cnt_q + 1'b1;
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    // Datapath and counter registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opd_q    <= opd_d;
        end
    end

endmodule

// File: rtl/alu_iter_unit.sv
// Execute-stage ALU with valid/ready handshakes. Single-cycle ops are computed on
// the accept edge; MULU/DIVU run in alu_iter_muldiv. All outputs are registered.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             carry_out,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;

    logic [WIDTH:0]   add_ext;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_lo;
    logic             sc_carry;

    logic             md_start;
    logic             md_is_div;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic             md_done;

    assign add_ext = {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(carry_in);
    assign shamt   = b[SHW-1:0];

    // Single-cycle result straight from the input operands, used on the accept edge.
    always_comb begin
        sc_lo    = '0;
        sc_carry = 1'b0;
        case (op)
            OP_AND: sc_lo = a & b;
            OP_OR:  sc_lo = a | b;
            OP_ADD: {sc_carry, sc_lo} = add_ext;
            OP_SUB: begin
                sc_lo    = a - b;
                sc_carry = a >= b;
            end
            OP_XOR: sc_lo = a ^ b;
            OP_SRL: sc_lo = a >> shamt;
            OP_SLL: sc_lo = a << shamt;
            OP_SLT: sc_lo = WIDTH'($signed(a) < $signed(b));
            default: ;
        endcase
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start),
        .is_div (md_is_div),
        .a      (a),
        .b      (b),
        .res_lo (md_lo),
        .res_hi (md_hi),
        .done   (md_done)
    );

    // FSM next state and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        res_lo_d    = res_lo_q;
        res_hi_d    = res_hi_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        ill_d       = ill_q;
        md_start    = 1'b0;
        md_is_div   = (op == OP_DIVU);
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    res_lo_d   = '0;
                    res_hi_d   = '0;
                    carry_d    = 1'b0;
                    zero_d     = 1'b0;
                    dbz_d      = 1'b0;
                    ill_d      = 1'b0;
                    if (op_is_illegal(op)) begin
                        ill_d       = 1'b1;
                        zero_d      = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end else if (op == OP_MULU) begin
                        md_start = 1'b1;
                        state_d  = ST_MUL;
                    end else if (op == OP_DIVU) begin
                        if (b == '0) begin
                            res_lo_d    = '1;
                            res_hi_d    = a;
                            dbz_d       = 1'b1;
                            out_valid_d = 1'b1;
                            state_d     = ST_DONE;
                        end else begin
                            md_start = 1'b1;
                            state_d  = ST_DIV;
                        end
                    end else begin
                        res_lo_d    = sc_lo;
                        carry_d     = sc_carry;
                        zero_d      = (sc_lo == '0);
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_done) begin
                    res_lo_d    = md_lo;
                    res_hi_d    = md_hi;
                    zero_d      = (md_lo == '0);
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // FSM state and output registers; reset lands in IDLE with only in_ready high.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values;
        // blocking = here would make later flops see this cycle's updates.
        if (reset) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_lo_q    <= '0;
            res_hi_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            res_lo_q    <= res_lo_d;
            res_hi_q    <= res_hi_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            ill_q       <= ill_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign res_lo      = res_lo_q;
    assign res_hi      = res_hi_q;
    assign carry_out   = carry_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_iter_unit.sv
// Scoreboard bench for alu_iter_unit at WIDTH=32: expected results are queued when
// an op is driven and compared when out_valid appears.
module tb_alu_iter_unit;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         carry_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res_lo, res_hi;
    logic         carry_out, zero, div_by_zero, illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         carry;
        logic         zero;
        logic         dbz;
        logic         ill;
        int           lat;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_iter_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .res_lo      (res_lo),
        .res_hi      (res_hi),
        .carry_out   (carry_out),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour written from the opcode table, independent of the RTL.
    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic ci);
        exp_t   e;
        logic [W:0]    s;
        logic [63:0]   p;
        e.lo = '0; e.hi = '0; e.carry = 1'b0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1;
        case (o)
            4'd0: e.lo = x & y;
            4'd1: e.lo = x | y;
            4'd2: begin
                s = {1'b0, x} + {1'b0, y} + {32'd0, ci};
                e.lo = s[W-1:0];
                e.carry = s[W];
            end
            4'd3: begin
                e.lo = x - y;
                e.carry = (x >= y);
            end
            4'd4: e.lo = x ^ y;
            4'd5: e.lo = x >> y[4:0];
            4'd6: e.lo = x << y[4:0];
            4'd7: e.lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd8: begin
                p = {32'd0, x} * {32'd0, y};
                e.lo = p[31:0];
                e.hi = p[63:32];
                e.lat = W + 1;
            end
            4'd9: begin
                if (y == 0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = x;
                    e.dbz = 1'b1;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                    e.lat = W + 1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.lo == 0);
        return e;
    endfunction

    // Drive one op, wait for its result, compare against the scoreboard head.
    // With hold > 0 the consumer stalls for that many cycles while extra requests arrive.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic ci, input int hold);
        exp_t  e;
        int    lat;
        int    waited;
        string t;
        t = $sformatf("op%0d a=%h b=%h", o, x, y);
        waited = 0;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check({t, " in_ready before accept"}, in_ready, 1);
        op = o; a = x; b = y; carry_in = ci;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        exp_q.push_back(model(o, x, y, ci));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        if (o == OP_MULU) check({t, " in_ready while busy"}, in_ready, 0);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({t, " out_valid"}, out_valid, 1);
        if (exp_q.size() == 0) begin
            check({t, " scoreboard empty"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check({t, " latency"}, lat, e.lat);
            check({t, " res_lo"}, res_lo, e.lo);
            check({t, " res_hi"}, res_hi, e.hi);
            check({t, " carry_out"}, carry_out, e.carry);
            check({t, " zero"}, zero, e.zero);
            check({t, " div_by_zero"}, div_by_zero, e.dbz);
            check({t, " illegal_op"}, illegal_op, e.ill);
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                op = OP_XOR;
                a = $urandom;
                b = $urandom;
                @(negedge clk);
                check($sformatf("hold%0d out_valid", i), out_valid, 1);
                check($sformatf("hold%0d in_ready", i), in_ready, 0);
                check($sformatf("hold%0d res_lo", i), res_lo, e.lo);
                check($sformatf("hold%0d res_hi", i), res_hi, e.hi);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({t, " out_valid after consume"}, out_valid, 0);
        check({t, " in_ready after consume"}, in_ready, 1);
    endtask

    // Overall time limit in case anything in the bench itself stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stale;
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;
        reset = 1'b1;
        in_valid = 1'b0;
        op = '0; a = '0; b = '0; carry_in = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset res_lo", res_lo, 0);
        check("reset res_hi", res_hi, 0);
        check("reset flags", {carry_out, zero, div_by_zero, illegal_op}, 0);

        run_op(OP_ADD,  32'hFFFF_FFFF, 32'h0, 1'b1, 0);
        run_op(OP_SRL,  32'h8000_0110, 32'd3, 1'b0, 0);
        run_op(OP_SLT,  32'h8000_0000, 32'd1, 1'b0, 0);
        run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, 0);
        run_op(OP_DIVU, 32'h1234, 32'd0, 1'b0, 0);
        run_op(4'b1100, 32'h1234_5678, 32'h9, 1'b0, 0);
        run_op(OP_SUB,  32'd5, 32'd5, 1'b0, 0);
        run_op(OP_SUB,  32'd3, 32'd5, 1'b0, 0);
        run_op(OP_SLL,  32'h0000_0001, 32'd31, 1'b0, 0);
        run_op(OP_DIVU, 32'd7, 32'd100, 1'b0, 0);
        run_op(OP_MULU, 32'h0001_0000, 32'h0001_0000, 1'b0, 0);

        // Consumer stall in DONE with fresh requests arriving.
        run_op(OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b1, 10);

        // Reset in the middle of a multiply.
        while (!in_ready) @(negedge clk);
        op = OP_MULU; a = 32'hDEAD_BEEF; b = 32'h1234_5678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid-mul reset out_valid", out_valid, 0);
        check("mid-mul reset in_ready", in_ready, 1);
        check("mid-mul reset res_lo", res_lo, 0);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("no result after aborted mul", stale, 0);
        run_op(OP_ADD, 32'd40, 32'd2, 1'b0, 0);

        // Random mix over the full opcode space, including illegal codes.
        for (int i = 0; i < 24; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (i % 4 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
